// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle for imm_gen_pipe: instruction/immsrc in, immediate out.
// The slave modport is the generator side; the master modport is the producer/consumer side.
interface imm_gen_pipe_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [2:0]      immsrc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_out;
  logic            imm_err;

  modport master (
    output in_valid, instruction, immsrc, out_ready,
    input  in_ready, out_valid, imm_out, imm_err
  );

  modport slave (
    input  in_valid, instruction, immsrc, out_ready,
    output in_ready, out_valid, imm_out, imm_err
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry skid buffer, flush,
// and a saturating illegal-type counter.
module imm_gen_pipe #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned AUTO_DEC  = 0,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count,
  imm_gen_pipe_if.slave        bus
);

  typedef enum logic [2:0] {
    T_I   = 3'b000,
    T_S   = 3'b001,
    T_B   = 3'b010,
    T_U   = 3'b011,
    T_J   = 3'b100,
    T_Z   = 3'b101,
    T_SH  = 3'b110,
    T_ERR = 3'b111
  } imm_type_e;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } occ_e;

  occ_e            state, state_nx;
  imm_type_e       typ;
  logic [XLEN-1:0] imm_c;
  logic            err_c;
  logic            accept;
  logic            ld_main, ld_skid, mv_skid;
  logic [XLEN-1:0] main_imm, skid_imm;
  logic            main_err, skid_err;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  always_comb begin
    typ = T_ERR;
    if (AUTO_DEC != 0) begin
      case (bus.instruction[6:0])
        7'b0010011: typ = (bus.instruction[13:12] == 2'b01) ? T_SH : T_I;
        7'b0000011,
        7'b1100111: typ = T_I;
        7'b0100011: typ = T_S;
        7'b1100011: typ = T_B;
        7'b0110111,
        7'b0010111: typ = T_U;
        7'b1101111: typ = T_J;
        7'b1110011: typ = bus.instruction[14] ? T_Z : T_I;
        default:    typ = T_ERR;
      endcase
    end else begin
      typ = imm_type_e'(bus.immsrc);
    end
  end

  always_comb begin
    imm_c = '0;
    err_c = 1'b0;
    case (typ)
      T_I:  imm_c = sext32({{20{bus.instruction[31]}}, bus.instruction[31:20]});
      T_S:  imm_c = sext32({{20{bus.instruction[31]}}, bus.instruction[31:25],
                            bus.instruction[11:7]});
      T_B:  imm_c = sext32({{19{bus.instruction[31]}}, bus.instruction[31],
                            bus.instruction[7], bus.instruction[30:25],
                            bus.instruction[11:8], 1'b0});
      T_U:  imm_c = sext32({bus.instruction[31:12], 12'b0});
      T_J:  imm_c = sext32({{11{bus.instruction[31]}}, bus.instruction[31],
                            bus.instruction[19:12], bus.instruction[20],
                            bus.instruction[30:21], 1'b0});
      T_Z:  imm_c[4:0] = bus.instruction[19:15];
      T_SH: begin
        if (XLEN == 64) imm_c[5:0] = bus.instruction[25:20];
        else            imm_c[4:0] = bus.instruction[24:20];
      end
      default: err_c = 1'b1;
    endcase
  end

  // in_ready comes only from the occupancy register, never from out_ready.
  assign bus.in_ready  = (state != S_TWO);
  assign bus.out_valid = (state != S_EMPTY);
  assign bus.imm_out   = main_imm;
  assign bus.imm_err   = main_err;
  assign accept        = bus.in_valid & bus.in_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    mv_skid  = 1'b0;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            ld_main  = 1'b1;
            state_nx = S_ONE;
          end
        end
        S_ONE: begin
          if (bus.out_ready) begin
            if (accept) ld_main = 1'b1;
            else        state_nx = S_EMPTY;
          end else if (accept) begin
            ld_skid  = 1'b1;
            state_nx = S_TWO;
          end
        end
        S_TWO: begin
          if (bus.out_ready) begin
            mv_skid  = 1'b1;
            state_nx = S_ONE;
          end
        end
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_imm <= '0;
      main_err <= 1'b0;
      skid_imm <= '0;
      skid_err <= 1'b0;
    end else begin
      if (mv_skid) begin
        main_imm <= skid_imm;
        main_err <= skid_err;
      end else if (ld_main) begin
        main_imm <= imm_c;
        main_err <= err_c;
      end
      if (ld_skid) begin
        skid_imm <= imm_c;
        skid_err <= err_c;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (accept && err_c && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations (32-bit immsrc, 64-bit, auto-decode)
// checked against a per-instance queue of expected immediates.
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_a, clr_a, flush_b, clr_b, flush_c, clr_c;
  logic [1:0] cnt_a;
  logic [7:0] cnt_b, cnt_c;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  int checks   = 0;
  int failures = 0;

  imm_gen_pipe_if #(.XLEN(32)) ba ();
  imm_gen_pipe_if #(.XLEN(64)) bb ();
  imm_gen_pipe_if #(.XLEN(32)) bc ();

  imm_gen_pipe #(.XLEN(32), .AUTO_DEC(0), .ERR_CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a), .err_clr(clr_a), .err_count(cnt_a), .bus(ba));
  imm_gen_pipe #(.XLEN(64), .AUTO_DEC(0), .ERR_CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b), .err_clr(clr_b), .err_count(cnt_b), .bus(bb));
  imm_gen_pipe #(.XLEN(32), .AUTO_DEC(1), .ERR_CNT_W(8)) u_c (
    .clk(clk), .rst(rst), .flush(flush_c), .err_clr(clr_c), .err_count(cnt_c), .bus(bc));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pop_chk(input int d, input logic [63:0] imm, input logic err, input string tag);
    exp_t e;
    logic have;
    have = 1'b0;
    e    = '0;
    case (d)
      0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
    endcase
    checks++;
    assert (have) else begin
      failures++;
      $error("FAIL %s_unexpected observed=0x%0h expected=none", tag, imm);
    end
    if (have) begin
      chk({tag, "_imm"}, imm, e.imm);
      chk({tag, "_err"}, {63'b0, err}, {63'b0, e.err});
    end
  endtask

  // Output side of the scoreboard: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (ba.out_valid && ba.out_ready) pop_chk(0, 64'(ba.imm_out), ba.imm_err, "a_out");
      if (bb.out_valid && bb.out_ready) pop_chk(1, bb.imm_out, bb.imm_err, "b_out");
      if (bc.out_valid && bc.out_ready) pop_chk(2, 64'(bc.imm_out), bc.imm_err, "c_out");
    end
  end

  task automatic start(input int d, input logic [31:0] ins, input logic [2:0] src);
    case (d)
      0: begin ba.in_valid = 1'b1; ba.instruction = ins; ba.immsrc = src; end
      1: begin bb.in_valid = 1'b1; bb.instruction = ins; bb.immsrc = src; end
      default: begin bc.in_valid = 1'b1; bc.instruction = ins; bc.immsrc = src; end
    endcase
  endtask

  task automatic wait_acc(input int d, input logic [63:0] ei, input logic ee, input string tag);
    logic acc, rdy, fl;
    exp_t e;
    acc = 1'b0;
    e.imm = ei;
    e.err = ee;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      case (d)
        0: begin rdy = ba.in_ready; fl = flush_a; end
        1: begin rdy = bb.in_ready; fl = flush_b; end
        default: begin rdy = bc.in_ready; fl = flush_c; end
      endcase
      if (rdy && !fl) begin
        acc = 1'b1;
        case (d)
          0: qa.push_back(e);
          1: qb.push_back(e);
          default: qc.push_back(e);
        endcase
      end
    end
    checks++;
    assert (acc) else begin
      failures++;
      $error("FAIL %s_accept observed=timeout expected=accepted", tag);
    end
    @(posedge clk); #1;
    case (d)
      0: ba.in_valid = 1'b0;
      1: bb.in_valid = 1'b0;
      default: bc.in_valid = 1'b0;
    endcase
  endtask

  task automatic send(input int d, input logic [31:0] ins, input logic [2:0] src,
                      input logic [63:0] ei, input logic ee, input string tag);
    start(d, ins, src);
    wait_acc(d, ei, ee, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    flush_a = 1'b0; clr_a = 1'b0; flush_b = 1'b0; clr_b = 1'b0; flush_c = 1'b0; clr_c = 1'b0;
    ba.in_valid = 1'b0; ba.instruction = '0; ba.immsrc = '0; ba.out_ready = 1'b1;
    bb.in_valid = 1'b0; bb.instruction = '0; bb.immsrc = '0; bb.out_ready = 1'b1;
    bc.in_valid = 1'b0; bc.instruction = '0; bc.immsrc = '0; bc.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(ba.out_valid), 64'd0);
    chk("rst_in_ready", 64'(ba.in_ready), 64'd1);
    chk("rst_imm_out", 64'(ba.imm_out), 64'd0);
    chk("rst_err_count", 64'(cnt_a), 64'd0);
    chk("rst_b_out_valid", 64'(bb.out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 32-bit, immsrc-selected types
    send(0, 32'hFFF00093, 3'b000, 64'h0000_0000_FFFF_FFFF, 1'b0, "a_I");
    chk("a_latency_valid", 64'(ba.out_valid), 64'd1);
    send(0, 32'hFE000EE3, 3'b010, 64'h0000_0000_FFFF_FFFC, 1'b0, "a_B");
    send(0, 32'h7E000FA3, 3'b001, 64'h0000_0000_0000_07FF, 1'b0, "a_S");
    send(0, 32'h800000B7, 3'b011, 64'h0000_0000_8000_0000, 1'b0, "a_U");
    send(0, 32'h8000006F, 3'b100, 64'h0000_0000_FFF0_0000, 1'b0, "a_J");
    send(0, 32'h000F8000, 3'b101, 64'h0000_0000_0000_001F, 1'b0, "a_Z");
    send(0, 32'h03F00000, 3'b110, 64'h0000_0000_0000_001F, 1'b0, "a_SH");
    send(0, 32'h12345678, 3'b111, 64'd0, 1'b1, "a_ill");

    // 64-bit extension
    send(1, 32'h800000B7, 3'b011, 64'hFFFF_FFFF_8000_0000, 1'b0, "b_U");
    send(1, 32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "b_I");
    send(1, 32'h03F00000, 3'b110, 64'h0000_0000_0000_003F, 1'b0, "b_SH");
    send(1, 32'h8000006F, 3'b100, 64'hFFFF_FFFF_FFF0_0000, 1'b0, "b_J");

    // auto-decode; immsrc deliberately set to junk
    send(2, 32'h4030D093, 3'b111, 64'd3, 1'b0, "c_srai");
    send(2, 32'h300FD073, 3'b111, 64'd31, 1'b0, "c_csrrwi");
    send(2, 32'h0000007F, 3'b000, 64'd0, 1'b1, "c_badop");
    send(2, 32'hFFF00013, 3'b111, 64'h0000_0000_FFFF_FFFF, 1'b0, "c_addi");
    send(2, 32'hFFC12E23, 3'b111, 64'h0000_0000_FFFF_FFFC, 1'b0, "c_sw");
    repeat (3) @(negedge clk);
    chk("c_err_count", 64'(cnt_c), 64'd1);
    chk("a_err_count_one", 64'(cnt_a), 64'd1);

    // FIFO ordering through the skid buffer under backpressure
    @(posedge clk); #1;
    ba.out_ready = 1'b0;
    send(0, 32'h00100093, 3'b000, 64'h0000_0000_0000_0001, 1'b0, "a_fifoA");
    send(0, 32'hFE000EE3, 3'b010, 64'h0000_0000_FFFF_FFFC, 1'b0, "a_fifoB");
    @(negedge clk);
    chk("a_in_ready_full", 64'(ba.in_ready), 64'd0);
    chk("a_hold_A", 64'(ba.imm_out), 64'h1);
    @(posedge clk); #1;
    start(0, 32'h7E000FA3, 3'b001);
    @(negedge clk);
    chk("a_C_held", 64'(ba.in_ready), 64'd0);
    chk("a_hold_A2", 64'(ba.imm_out), 64'h1);
    @(posedge clk); #1;
    ba.out_ready = 1'b1;
    wait_acc(0, 64'h0000_0000_0000_07FF, 1'b0, "a_fifoC");
    repeat (4) @(negedge clk);
    chk("a_fifo_drained", 64'(qa.size()), 64'd0);

    // err_count saturation and clear priority
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) send(0, 32'h0, 3'b111, 64'd0, 1'b1, "a_sat");
    @(negedge clk);
    chk("a_err_sat", 64'(cnt_a), 64'd3);
    @(posedge clk); #1;
    clr_a = 1'b1;
    send(0, 32'h0, 3'b111, 64'd0, 1'b1, "a_clr_ill");
    clr_a = 1'b0;
    @(negedge clk);
    chk("a_err_clr_wins", 64'(cnt_a), 64'd0);

    // flush with two entries buffered
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    ba.out_ready = 1'b0;
    send(0, 32'h0, 3'b111, 64'd0, 1'b1, "a_fl1");
    send(0, 32'hFFF00093, 3'b000, 64'h0000_0000_FFFF_FFFF, 1'b0, "a_fl2");
    @(negedge clk);
    chk("a_two_buffered", 64'(ba.in_ready), 64'd0);
    chk("a_cnt_before_flush", 64'(cnt_a), 64'd1);
    @(posedge clk); #1;
    flush_a = 1'b1;
    start(0, 32'h0, 3'b111);
    @(posedge clk); #1;
    flush_a = 1'b0;
    ba.in_valid = 1'b0;
    qa.delete();
    @(negedge clk);
    chk("a_flush_out_valid", 64'(ba.out_valid), 64'd0);
    chk("a_flush_in_ready", 64'(ba.in_ready), 64'd1);
    chk("a_flush_cnt", 64'(cnt_a), 64'd1);
    @(posedge clk); #1;
    ba.out_ready = 1'b1;
    // flush while empty and ready: the input must still be dropped
    flush_a = 1'b1;
    start(0, 32'h0, 3'b111);
    @(posedge clk); #1;
    flush_a = 1'b0;
    ba.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("a_flush_drop_valid", 64'(ba.out_valid), 64'd0);
    chk("a_flush_drop_cnt", 64'(cnt_a), 64'd1);

    // asynchronous reset mid-stall
    @(posedge clk); #1;
    ba.out_ready = 1'b0;
    send(0, 32'hFFF00093, 3'b000, 64'h0000_0000_FFFF_FFFF, 1'b0, "a_rs1");
    send(0, 32'h0, 3'b111, 64'd0, 1'b1, "a_rs2");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("a_rst_out_valid", 64'(ba.out_valid), 64'd0);
    chk("a_rst_in_ready", 64'(ba.in_ready), 64'd1);
    chk("a_rst_imm_out", 64'(ba.imm_out), 64'd0);
    chk("a_rst_imm_err", 64'(ba.imm_err), 64'd0);
    chk("a_rst_cnt", 64'(cnt_a), 64'd0);
    qa.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    ba.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("a_post_rst_idle", 64'(ba.out_valid), 64'd0);
    chk("b_drained", 64'(qb.size()), 64'd0);
    chk("c_drained", 64'(qc.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
